stack_ctrl: RTL and testbench

- Pointer/control side of the 8-entry x 4-bit stack memory (STACK_MEM).
- Accepts push/pop requests from the core (call/return, operand stack) and owns the TOS pointer and the Stack_Full flag.
- Drives the memory's PushEnbl/PopEnbl and flags when popped data is valid.
- Detects overflow and underflow, reports occupancy, and keeps sticky error flags until cleared.

---
 rtl/stack_ctrl.sv | 82 ++++++++
 tb/tb_stack_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Pointer/flag controller for an 8x4 stack memory; enables are combinational, Pop_Valid lags PopEnbl by 1 cycle.
// No backpressure: a request that cannot be honoured is dropped, with a sticky error flag recording why.
module stack_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Push_Req,
    input  logic              Pop_Req,
    input  logic [DATA_W-1:0] Push_Data,
    input  logic              Err_Clr,
    output logic              PushEnbl,
    output logic              PopEnbl,
    output logic [DATA_W-1:0] PushDataIn,
    output logic [0:ADDR_W-1] TOS,
    output logic              Stack_Full,
    output logic              Stack_Empty,
    output logic [ADDR_W:0]   Depth,
    output logic              Pop_Valid,
    output logic              Overflow_Err,
    output logic              Underflow_Err,
    output logic              Conflict_Err
);

    localparam logic [ADDR_W-1:0] TOP_SLOT  = '1;
    localparam logic [ADDR_W:0]   DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] tos_q;
    logic              full_q;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              unf_set;
    logic              cnf_set;

    // TOS stays parked on the top slot once full; the full bit alone marks the 8th entry
    assign empty   = (tos_q == '0) && !full_q;
    assign push_ok = !Reset && Push_Req && !Pop_Req && !full_q;
    assign pop_ok  = !Reset && Pop_Req && !Push_Req && !empty;
    assign ovf_set = Push_Req && !Pop_Req && full_q;
    assign unf_set = Pop_Req && !Push_Req && empty;
    assign cnf_set = Push_Req && Pop_Req;

    assign PushEnbl    = push_ok;
    assign PopEnbl     = pop_ok;
    assign PushDataIn  = Push_Data;
    assign TOS         = tos_q;
    assign Stack_Full  = full_q;
    assign Stack_Empty = empty;
    assign Depth       = full_q ? DEPTH_MAX : {1'b0, tos_q};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tos_q  <= '0;
            full_q <= 1'b0;
        end else if (push_ok) begin
            if (tos_q == TOP_SLOT) full_q <= 1'b1;
            else                   tos_q  <= tos_q + 1'b1;
        end else if (pop_ok) begin
            if (full_q) full_q <= 1'b0;
            else        tos_q  <= tos_q - 1'b1;
        end
    end

    // New error events take priority over a clear in the same cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Pop_Valid     <= 1'b0;
            Overflow_Err  <= 1'b0;
            Underflow_Err <= 1'b0;
            Conflict_Err  <= 1'b0;
        end else begin
            Pop_Valid     <= pop_ok;
            Overflow_Err  <= (Overflow_Err  && !Err_Clr) || ovf_set;
            Underflow_Err <= (Underflow_Err && !Err_Clr) || unf_set;
            Conflict_Err  <= (Conflict_Err  && !Err_Clr) || cnf_set;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed plan then random traffic against a queue-based stack model and an attached memory.
module tb_stack_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Push_Req;
    logic       Pop_Req;
    logic [3:0] Push_Data;
    logic       Err_Clr;
    logic       PushEnbl;
    logic       PopEnbl;
    logic [3:0] PushDataIn;
    logic [0:2] TOS;
    logic       Stack_Full;
    logic       Stack_Empty;
    logic [3:0] Depth;
    logic       Pop_Valid;
    logic       Overflow_Err;
    logic       Underflow_Err;
    logic       Conflict_Err;

    int checks   = 0;
    int failures = 0;

    // reference stack (back = top), expected pop data, sticky error model
    int stk[$];
    int exp_q[$];
    bit m_ovf, m_unf, m_cnf;

    // simple memory that follows the controller's pointer semantics
    logic [3:0] mem [8];
    logic [3:0] pop_dat;
    logic [2:0] tos_v;

    always #5 Clk = ~Clk;

    stack_ctrl #(.ADDR_W(3), .DATA_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Push_Req(Push_Req), .Pop_Req(Pop_Req),
        .Push_Data(Push_Data), .Err_Clr(Err_Clr), .PushEnbl(PushEnbl), .PopEnbl(PopEnbl),
        .PushDataIn(PushDataIn), .TOS(TOS), .Stack_Full(Stack_Full), .Stack_Empty(Stack_Empty),
        .Depth(Depth), .Pop_Valid(Pop_Valid), .Overflow_Err(Overflow_Err),
        .Underflow_Err(Underflow_Err), .Conflict_Err(Conflict_Err)
    );

    assign tos_v = TOS;

    always @(posedge Clk) begin
        if (PushEnbl) mem[tos_v] <= PushDataIn;
        if (PopEnbl)  pop_dat <= Stack_Full ? mem[tos_v] : mem[tos_v - 3'd1];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every Pop_Valid must match the oldest outstanding expected pop
    always @(negedge Clk) begin
        if (Pop_Valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_valid_unexpected: got data %0d expected no pop at %0t", pop_dat, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(pop_dat) != e) begin
                    failures++;
                    $display("FAIL pop_data: got %0d expected %0d at %0t", pop_dat, e, $time);
                end
            end
        end
    end

    function automatic int exp_tos();
        return (stk.size() == 8) ? 7 : stk.size();
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_tos"},   int'(TOS),         exp_tos());
        chk({tag, "_depth"}, int'(Depth),       stk.size());
        chk({tag, "_full"},  int'(Stack_Full),  int'(stk.size() == 8));
        chk({tag, "_empty"}, int'(Stack_Empty), int'(stk.size() == 0));
        chk({tag, "_ovf"},   int'(Overflow_Err),  int'(m_ovf));
        chk({tag, "_unf"},   int'(Underflow_Err), int'(m_unf));
        chk({tag, "_cnf"},   int'(Conflict_Err),  int'(m_cnf));
    endtask

    task automatic model_reset();
        stk.delete();
        exp_q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_cnf = 0;
    endtask

    task automatic do_cycle(input bit push, input bit pop, input int data, input bit clr);
        bit pok, uok;
        @(negedge Clk);
        Push_Req  = push;
        Pop_Req   = pop;
        Push_Data = 4'(data);
        Err_Clr   = clr;
        pok = push && !pop && stk.size() < 8;
        uok = pop && !push && stk.size() > 0;
        #1;
        chk("push_enbl",    int'(PushEnbl),   int'(pok));
        chk("pop_enbl",     int'(PopEnbl),    int'(uok));
        chk("push_data_in", int'(PushDataIn), data & 15);
        @(posedge Clk);
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
            m_cnf = 0;
        end
        if (push && !pop && stk.size() == 8) m_ovf = 1;
        if (pop && !push && stk.size() == 0) m_unf = 1;
        if (push && pop) m_cnf = 1;
        if (pok) stk.push_back(data & 15);
        if (uok) exp_q.push_back(stk.pop_back());
        #1;
        chk("pop_valid", int'(Pop_Valid), int'(uok));
        chk_state("post");
    endtask

    // reset asserted between edges with a push pending: outputs must clear with no clock edge
    task automatic mid_reset();
        @(negedge Clk);
        Push_Req  = 1'b1;
        Pop_Req   = 1'b0;
        Push_Data = 4'hC;
        Err_Clr   = 1'b0;
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_push_enbl", int'(PushEnbl),  0);
        chk("rst_pop_enbl",  int'(PopEnbl),   0);
        chk("rst_pop_valid", int'(Pop_Valid), 0);
        chk_state("rst");
        @(negedge Clk);
        Reset    = 1'b0;
        Push_Req = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Push_Req = 0; Pop_Req = 0; Push_Data = 0; Err_Clr = 0;
        model_reset();
        #2;
        chk("init_pop_valid", int'(Pop_Valid), 0);
        chk_state("init");
        @(negedge Clk);
        Reset = 1'b0;

        do_cycle(1, 0, 5, 0);
        do_cycle(1, 1, 0, 0);
        mid_reset();

        for (int i = 1; i <= 8; i++) do_cycle(1, 0, i, 0);
        do_cycle(1, 0, 9, 0);
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 0, 1);

        for (int i = 0; i < 8; i++) do_cycle(0, 1, 0, 0);
        do_cycle(0, 1, 0, 0);
        do_cycle(0, 1, 0, 1);
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 0, 1);

        for (int i = 0; i < 3; i++) do_cycle(1, 0, i + 3, 0);
        do_cycle(1, 1, 0, 0);
        do_cycle(1, 0, 10, 0);
        do_cycle(0, 1, 0, 0);
        do_cycle(0, 0, 0, 1);

        // random traffic with phases biased toward filling and draining
        for (int i = 0; i < 600; i++) begin
            int bias;
            bit p, q, c;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            p = ($urandom_range(99) < bias);
            q = ($urandom_range(99) < (100 - bias));
            c = ($urandom_range(15) == 0);
            do_cycle(p, q, int'($urandom_range(15)), c);
            if (i == 333) mid_reset();
        end

        do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 0, 0);
        chk("outstanding_pops", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
